// File: rtl/wb_sram_slave.sv
// Wishbone B4 pipelined slave backed by a word-addressed on-chip SRAM.
// One request per cycle, byte-masked writes, in-order ack/err responses
// after a fixed latency, and stall once the outstanding budget is full.
module wb_sram_slave #(
  parameter int unsigned MemWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter string       MemInitFile    = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o
);

  localparam int unsigned AW = $clog2(MemWords);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } stage_t;

  logic [31:0]   mem [MemWords];
  stage_t        pipe [Latency];
  logic [CW-1:0] count;
  logic          rst_nq;

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          accept;
  logic          retire;
  logic          unused_adr_lsb;

  // Unsigned subtraction wraps addresses below BaseAddr far past the window,
  // so a single upper-bits-zero test covers both range bounds.
  assign offset         = wb_adr_i - BaseAddr;
  assign in_range       = (offset[31:AW+2] == '0);
  assign idx            = offset[AW+1:2];
  assign unused_adr_lsb = ^offset[1:0];

  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign retire     = pipe[Latency-1].valid;
  assign wb_stall_o = ~rst_nq | (count == MaxCnt) | ~wb_cyc_i;

  assign wb_ack_o = pipe[Latency-1].valid & ~pipe[Latency-1].err & wb_cyc_i;
  assign wb_err_o = pipe[Latency-1].valid &  pipe[Latency-1].err & wb_cyc_i;
  assign wb_dat_o = wb_ack_o ? pipe[Latency-1].data : 32'h0;

  // Byte-masked write at the accepting edge; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  // Response pipeline and outstanding counter; dropping cyc aborts everything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rst_nq <= 1'b0;
      count  <= '0;
      for (int s = 0; s < Latency; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      rst_nq <= 1'b1;
      for (int s = Latency - 1; s > 0; s--) begin
        pipe[s] <= pipe[s-1];
      end
      pipe[0].valid <= accept;
      pipe[0].err   <= ~in_range;
      pipe[0].data  <= (in_range && !wb_we_i) ? mem[idx] : 32'h0;
      if (!wb_cyc_i) begin
        count <= '0;
        for (int s = 0; s < Latency; s++) begin
          pipe[s].valid <= 1'b0;
        end
      end else begin
        case ({accept, retire})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
